spi_wave: RTL and testbench

- SPI slave receiver (mode 0: CPOL=0, CPHA=0, MSB first) that deserialises words from an external SPI master.
- Fully synchronous to the system clock `clk`. SCK, SSEL and MOSI are treated as asynchronous inputs and oversampled through synchronisers.
- Presents each completed word on DATA_OUT with a one-cycle DATA_READY strobe.
- Sits between the board-level SPI pins and the waveform/command logic that consumes 16-bit words.

---
 rtl/spi_wave.sv | 89 ++++++++
 tb/tb_spi_wave.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/spi_wave.sv
// spi_wave: SPI mode-0 (CPOL=0, CPHA=0, MSB first) slave receiver.
// Oversamples SCK/SSEL/MOSI on clk and deserialises WORD_BITS-bit words.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      high = receiver active; low = SCK ignored, bit counter cleared
//   SCK         SPI clock from master (asynchronous)
//   MOSI        serial data from master (asynchronous)
//   SSEL        active-low chip select (asynchronous)
//   DATA_OUT    last complete word; MSB was first on the wire
//   DATA_READY  one-clk pulse marking a DATA_OUT update

module spi_wave #(
    parameter int WORD_BITS   = 16,
    parameter int SYNC_STAGES = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 SCK,
    input  logic                 MOSI,
    input  logic                 SSEL,
    output logic [WORD_BITS-1:0] DATA_OUT,
    output logic                 DATA_READY
);

    localparam int            CW   = $clog2(WORD_BITS);
    localparam logic [CW-1:0] LAST = CW'(WORD_BITS - 1);

    // Index 0 is the newest sample; the highest index is the oldest.
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] ssel_sync;
    // MOSI is one stage shorter than SCK so the data bit is already settled
    // when the matching SCK rise reaches the edge detector.
    logic [SYNC_STAGES-2:0] mosi_sync;

    logic [WORD_BITS-1:0] shift_reg;
    logic [CW-1:0]        bit_cnt;

    logic sck_rise;
    logic ssel_active;
    logic mosi_bit;
    logic accept;

    // Only the rising SCK edge matters for a receive-only mode-0 slave, so
    // the falling-edge decode is not built.
    assign sck_rise    = (sck_sync[SYNC_STAGES-1] == 1'b0) && (sck_sync[SYNC_STAGES-2] == 1'b1);
    assign ssel_active = ~ssel_sync[SYNC_STAGES-1];
    assign mosi_bit    = mosi_sync[SYNC_STAGES-2];
    assign accept      = sck_rise && ssel_active && enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= '0;
            ssel_sync <= '1;
            mosi_sync <= '0;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
            ssel_sync <= {ssel_sync[SYNC_STAGES-2:0], SSEL};
            mosi_sync <= {mosi_sync[SYNC_STAGES-3:0], MOSI};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            DATA_OUT   <= '0;
            DATA_READY <= 1'b0;
        end else begin
            DATA_READY <= 1'b0;
            if (!ssel_active || !enable) begin
                // Deselect or disable discards any partial word.
                bit_cnt <= '0;
            end else if (accept) begin
                shift_reg <= {shift_reg[WORD_BITS-2:0], mosi_bit};
                if (bit_cnt == LAST) begin
                    DATA_OUT   <= {shift_reg[WORD_BITS-2:0], mosi_bit};
                    DATA_READY <= 1'b1;
                    bit_cnt    <= '0;
                end else begin
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_wave.sv
// tb_spi_wave: directed bench for spi_wave. Drives SPI mode-0 frames with
// 100 ns SCK half-periods against a 10 ns clk and checks DATA_OUT and the
// DATA_READY pulse count/width after each scenario.

module tb_spi_wave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        SCK = 1'b0;
    logic        MOSI = 1'b0;
    logic        SSEL = 1'b1;
    logic [15:0] DATA_OUT;
    logic        DATA_READY;

    int n_cmp = 0;
    int n_err = 0;

    // Running totals of DATA_READY pulses and of clk cycles it was high;
    // equal deltas across a scenario mean every pulse lasted one cycle.
    int  rdy_pulses = 0;
    int  rdy_cycles = 0;
    logic rdy_prev = 1'b0;

    int p0, c0;

    spi_wave #(.WORD_BITS(16), .SYNC_STAGES(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .SCK        (SCK),
        .MOSI       (MOSI),
        .SSEL       (SSEL),
        .DATA_OUT   (DATA_OUT),
        .DATA_READY (DATA_READY)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (DATA_READY) rdy_cycles++;
        if (DATA_READY && !rdy_prev) rdy_pulses++;
        rdy_prev = DATA_READY;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Shift out the n most significant bits of w, MSB first. MOSI changes
    // while SCK is low; each bit is followed by a falling edge.
    task automatic send_bits(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            MOSI = w[15-i];
            #100 SCK = 1'b1;
            #100 SCK = 1'b0;
        end
        #100;
    endtask

    task automatic mark();
        p0 = rdy_pulses;
        c0 = rdy_cycles;
    endtask

    initial begin
        #20;
        check("reset_data", 32'(DATA_OUT), 32'h0);
        check("reset_ready", 32'(DATA_READY), 32'h0);
        rst_n = 1'b1;
        #40;

        // Basic word
        mark();
        SSEL = 1'b0;
        #100;
        send_bits(16'hA3A4, 16);
        check("basic_data", 32'(DATA_OUT), 32'hA3A4);
        check("basic_pulses", 32'(rdy_pulses - p0), 32'd1);
        check("basic_width", 32'(rdy_cycles - c0), 32'd1);
        SSEL = 1'b1;
        #100;

        // Back-to-back words under continuous select
        mark();
        SSEL = 1'b0;
        #100;
        send_bits(16'h1234, 16);
        check("b2b_first_data", 32'(DATA_OUT), 32'h1234);
        check("b2b_first_pulses", 32'(rdy_pulses - p0), 32'd1);
        send_bits(16'hFFFF, 16);
        check("b2b_second_data", 32'(DATA_OUT), 32'hFFFF);
        check("b2b_pulses", 32'(rdy_pulses - p0), 32'd2);
        check("b2b_width", 32'(rdy_cycles - c0), 32'd2);
        SSEL = 1'b1;
        #100;

        // Abort after 7 bits, then a fresh word
        mark();
        SSEL = 1'b0;
        #100;
        send_bits(16'hC3FF, 7);
        SSEL = 1'b1;
        #100;
        check("abort_partial_pulses", 32'(rdy_pulses - p0), 32'd0);
        SSEL = 1'b0;
        #100;
        send_bits(16'h00F0, 16);
        check("abort_data", 32'(DATA_OUT), 32'h00F0);
        check("abort_pulses", 32'(rdy_pulses - p0), 32'd1);
        SSEL = 1'b1;
        #100;

        // Enable gating
        mark();
        enable = 1'b0;
        SSEL = 1'b0;
        #100;
        send_bits(16'hA3A4, 16);
        check("enable_off_data", 32'(DATA_OUT), 32'h00F0);
        check("enable_off_pulses", 32'(rdy_pulses - p0), 32'd0);
        SSEL = 1'b1;
        enable = 1'b1;
        #100;
        SSEL = 1'b0;
        #100;
        send_bits(16'hA3A4, 16);
        check("enable_on_data", 32'(DATA_OUT), 32'hA3A4);
        check("enable_on_pulses", 32'(rdy_pulses - p0), 32'd1);

        // Reset mid-word (select stays low through the first 8 bits)
        send_bits(16'h5A00, 8);
        #3;
        rst_n = 1'b0;
        #1;
        check("midreset_data", 32'(DATA_OUT), 32'h0);
        check("midreset_ready", 32'(DATA_READY), 32'h0);
        SSEL = 1'b1;
        #16;
        rst_n = 1'b1;
        #100;
        mark();
        SSEL = 1'b0;
        #100;
        send_bits(16'h5A5A, 16);
        check("postreset_data", 32'(DATA_OUT), 32'h5A5A);
        check("postreset_pulses", 32'(rdy_pulses - p0), 32'd1);

        // Hold after deselect
        SSEL = 1'b1;
        #100;
        mark();
        for (int i = 0; i < 20; i++) begin
            MOSI = 1'($urandom_range(1, 0));
            #100 SCK = 1'b1;
            #100 SCK = 1'b0;
        end
        #100;
        check("hold_data", 32'(DATA_OUT), 32'h5A5A);
        check("hold_pulses", 32'(rdy_pulses - p0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
